// File: rtl/enc_ctrl_pkg.sv
// Shared types and constants for the front-panel encoder/button parameter controller.
package enc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } btn_state_e;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_UP,
    STEP_DOWN
  } step_e;

  // Fast-spin acceleration: steps closer together than ACCEL_WINDOW cycles are scaled by ACCEL_MULT
  localparam int          ACCEL_WINDOW = 4096;
  localparam int          ACCEL_MULT   = 4;
  localparam logic [15:0] GAP_MAX      = 16'hFFFF;

endpackage

// File: rtl/btn_debounce.sv
// Push-button synchroniser and press/release debouncer producing a one-cycle advance pulse
// when a press has been stable for DEBOUNCE_CYCLES samples.
module btn_debounce
  import enc_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_advance
);

  localparam int             CW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  C_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_btn_meta;
  logic          r_btn_s;
  btn_state_e    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_advance;
  logic [CW-1:0] w_cnt_next;

  assign w_cnt_next = r_cnt + CW'(1);
  assign o_advance  = r_advance;

  // The IDLE/HELD sample counts as the first stable sample, so DEBOUNCE_CYCLES samples total
  always_ff @(posedge clk) begin
    if (reset) begin
      r_btn_meta <= 1'b0;
      r_btn_s    <= 1'b0;
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_advance  <= 1'b0;
    end else begin
      r_btn_meta <= i_btn;
      r_btn_s    <= r_btn_meta;
      r_advance  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_btn_s) begin
            r_state <= PRESS_WAIT;
            r_cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!r_btn_s) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= w_cnt_next;
            if (w_cnt_next == C_LAST) begin
              r_state   <= HELD;
              r_advance <= 1'b1;
            end
          end
        end
        HELD: begin
          if (!r_btn_s) begin
            r_state <= RELEASE_WAIT;
            r_cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (r_btn_s) begin
            r_state <= HELD;
          end else begin
            r_cnt <= w_cnt_next;
            if (w_cnt_next == C_LAST) begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/encoder_param_ctrl.sv
// Shares one quadrature encoder and push button across NUM_PARAMS saturating parameter registers.
// Optional macro ENC_ACCEL_EN enables step acceleration for fast encoder spins.
module encoder_param_ctrl
  import enc_ctrl_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int NUM_PARAMS      = 3,
  parameter int MIN_VAL         = 0,
  parameter int MAX_VAL         = 255,
  parameter int INIT_VAL        = 128,
  parameter int STEP            = 1,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enc_a,
  input  logic                        enc_b,
  input  logic                        btn,
  output logic [2:0]                  sel,
  output logic [NUM_PARAMS*WIDTH-1:0] params,
  output logic                        update,
  output logic [2:0]                  update_idx
);

  localparam logic [WIDTH:0]   C_MAX      = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   C_MIN      = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH-1:0] C_MAX_W    = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] C_MIN_W    = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] C_INIT     = WIDTH'(INIT_VAL);
  localparam logic [WIDTH:0]   C_STEP     = (WIDTH+1)'(STEP);
  localparam logic [2:0]       C_LAST_SEL = 3'(NUM_PARAMS - 1);

  logic                                r_a_meta, r_a_s, r_pa;
  logic                                r_b_meta, r_b_s, r_pb;
  logic                                r_primed;
  step_e                               r_step;
  step_e                               w_step_dec;
  logic [NUM_PARAMS-1:0][WIDTH-1:0]    r_params;
  logic [2:0]                          r_sel;
  logic                                r_update;
  logic [2:0]                          r_update_idx;
  logic                                w_advance;
  logic [WIDTH:0]                      w_step_sz;
  logic [WIDTH:0]                      w_sum;
  logic [WIDTH-1:0]                    w_old;
  logic [WIDTH-1:0]                    w_new;
  logic                                w_changed;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk      (clk),
    .reset    (reset),
    .i_btn    (btn),
    .o_advance(w_advance)
  );

  always_comb begin
    w_step_dec = STEP_NONE;
    case ({r_a_s, r_pa, r_b_s, r_pb})
      4'b1000, 4'b0111: w_step_dec = STEP_UP;
      4'b0010, 4'b1101: w_step_dec = STEP_DOWN;
      default:          w_step_dec = STEP_NONE;
    endcase
  end

`ifdef ENC_ACCEL_EN
  localparam logic [WIDTH:0] C_STEP_ACC = (WIDTH+1)'(ACCEL_MULT * STEP);

  logic [15:0] r_gap;

  // Reset parks the gap at its ceiling so the first step after reset is never accelerated
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gap <= GAP_MAX;
    end else if (r_step != STEP_NONE) begin
      r_gap <= '0;
    end else if (r_gap != GAP_MAX) begin
      r_gap <= r_gap + 16'd1;
    end
  end

  assign w_step_sz = (r_gap < 16'(ACCEL_WINDOW)) ? C_STEP_ACC : C_STEP;
`else
  assign w_step_sz = C_STEP;
`endif

  assign w_sum = {1'b0, w_old} + w_step_sz;

  // Arithmetic is one bit wider than the register so saturation never sees a wrapped value
  always_comb begin
    w_old     = r_params[0];
    w_new     = r_params[0];
    w_changed = 1'b0;
    for (int i = 0; i < NUM_PARAMS; i++) begin
      if (r_sel == 3'(i)) w_old = r_params[i];
    end
    case (r_step)
      STEP_UP:   w_new = (w_sum > C_MAX) ? C_MAX_W : w_sum[WIDTH-1:0];
      STEP_DOWN: w_new = ({1'b0, w_old} < (C_MIN + w_step_sz)) ? C_MIN_W
                                                                : (w_old - w_step_sz[WIDTH-1:0]);
      default:   w_new = w_old;
    endcase
    w_changed = (r_step != STEP_NONE) && (w_new != w_old);
  end

  // A step landing with an advance pulse uses the pre-advance selection
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_meta     <= 1'b0;
      r_a_s        <= 1'b0;
      r_pa         <= 1'b0;
      r_b_meta     <= 1'b0;
      r_b_s        <= 1'b0;
      r_pb         <= 1'b0;
      r_primed     <= 1'b0;
      r_step       <= STEP_NONE;
      r_sel        <= '0;
      r_update     <= 1'b0;
      r_update_idx <= '0;
      for (int i = 0; i < NUM_PARAMS; i++) r_params[i] <= C_INIT;
    end else begin
      r_a_meta <= enc_a;
      r_a_s    <= r_a_meta;
      r_pa     <= r_a_s;
      r_b_meta <= enc_b;
      r_b_s    <= r_b_meta;
      r_pb     <= r_b_s;
      r_primed <= 1'b1;
      r_step   <= r_primed ? w_step_dec : STEP_NONE;
      r_update <= w_changed;
      if (w_changed) begin
        r_update_idx <= r_sel;
        for (int i = 0; i < NUM_PARAMS; i++) begin
          if (r_sel == 3'(i)) r_params[i] <= w_new;
        end
      end
      if (w_advance) begin
        r_sel <= (r_sel == C_LAST_SEL) ? 3'd0 : r_sel + 3'd1;
      end
    end
  end

  assign sel        = r_sel;
  assign params     = r_params;
  assign update     = r_update;
  assign update_idx = r_update_idx;

endmodule

// File: tb/tb_encoder_param_ctrl.sv
// Directed scoreboard bench for encoder_param_ctrl: predicted updates are queued when pins move
// and matched (index, value, arrival cycle) whenever the DUT pulses update.
module tb_encoder_param_ctrl;

   localparam int WIDTH           = 8;
   localparam int NUM_PARAMS      = 3;
   localparam int MIN_VAL         = 0;
   localparam int MAX_VAL         = 255;
   localparam int INIT_VAL        = 128;
   localparam int STEP            = 1;
   localparam int DEBOUNCE_CYCLES = 16;

   logic                        clk = 1'b0;
   logic                        reset;
   logic                        enc_a;
   logic                        enc_b;
   logic                        btn;
   logic [2:0]                  sel;
   logic [NUM_PARAMS*WIDTH-1:0] params;
   logic                        update;
   logic [2:0]                  update_idx;

   typedef struct {
      int idx;
      int val;
      int cycle;
   } expect_t;

   expect_t sbq[$];
   int      errors = 0;
   int      checks = 0;
   int      cyc    = 0;
   int      modelP[NUM_PARAMS];
   int      modelSel;
   logic    prevA;
   logic    prevB;
`ifdef ENC_ACCEL_EN
   int      lastApply;
`endif

   encoder_param_ctrl #(
      .WIDTH          (WIDTH),
      .NUM_PARAMS     (NUM_PARAMS),
      .MIN_VAL        (MIN_VAL),
      .MAX_VAL        (MAX_VAL),
      .INIT_VAL       (INIT_VAL),
      .STEP           (STEP),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enc_a     (enc_a),
      .enc_b     (enc_b),
      .btn       (btn),
      .sel       (sel),
      .params    (params),
      .update    (update),
      .update_idx(update_idx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Every update pulse must match the oldest prediction in index, value and arrival cycle
   always @(posedge clk) begin
      expect_t e;
      #1;
      if (reset === 1'b0 && update !== 1'b0) begin
         checks++;
         assert (sbq.size() > 0) else begin
            errors++;
            $error("[TB] FAIL unexpected_update observed idx=%0d expected no update", update_idx);
         end
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            checkOutput("upd_idx", 32'(update_idx), e.idx);
            checkOutput("upd_val", 32'(params[e.idx*WIDTH +: WIDTH]), e.val);
            checkOutput("upd_cycle", cyc, e.cycle);
         end
      end
   end

   // Called at a negedge; a pin change taken at the next edge shows on params three edges later
   task automatic applyStimulus(input logic a, input logic b, input int hold);
      logic [3:0] code;
      int applyCyc;
      int sz;
      int oldV;
      int newV;
      code     = {a, prevA, b, prevB};
      applyCyc = cyc + 4;
      sz       = STEP;
      if (code == 4'b1000 || code == 4'b0111 || code == 4'b0010 || code == 4'b1101) begin
`ifdef ENC_ACCEL_EN
         if (lastApply >= 0 && (applyCyc - lastApply - 1) < 4096) sz = 4 * STEP;
         lastApply = applyCyc;
`endif
         oldV = modelP[modelSel];
         if (code == 4'b1000 || code == 4'b0111)
            newV = (oldV + sz > MAX_VAL) ? MAX_VAL : oldV + sz;
         else
            newV = (oldV - sz < MIN_VAL) ? MIN_VAL : oldV - sz;
         if (newV != oldV) begin
            modelP[modelSel] = newV;
            sbq.push_back('{modelSel, newV, applyCyc});
         end
      end
      enc_a = a;
      enc_b = b;
      prevA = a;
      prevB = b;
      repeat (hold) @(negedge clk);
   endtask

   task automatic cwCycle();
      applyStimulus(1'b1, 1'b0, 3);
      applyStimulus(1'b1, 1'b1, 3);
      applyStimulus(1'b0, 1'b1, 3);
      applyStimulus(1'b0, 1'b0, 3);
   endtask

   task automatic ccwCycle();
      applyStimulus(1'b0, 1'b1, 3);
      applyStimulus(1'b1, 1'b1, 3);
      applyStimulus(1'b1, 1'b0, 3);
      applyStimulus(1'b0, 1'b0, 3);
   endtask

   task automatic pressButton(input int high, input int low);
      btn = 1'b1;
      repeat (high) @(negedge clk);
      btn = 1'b0;
      repeat (low) @(negedge clk);
      if (high >= DEBOUNCE_CYCLES) modelSel = (modelSel == NUM_PARAMS - 1) ? 0 : modelSel + 1;
   endtask

   task automatic doReset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < NUM_PARAMS; i++) modelP[i] = INIT_VAL;
      modelSel = 0;
      sbq.delete();
      prevA = enc_a;
      prevB = enc_b;
`ifdef ENC_ACCEL_EN
      lastApply = -1;
`endif
   endtask

   task automatic checkState(input string tag);
      for (int i = 0; i < NUM_PARAMS; i++)
         checkOutput($sformatf("%s_p%0d", tag, i), 32'(params[i*WIDTH +: WIDTH]), modelP[i]);
      checkOutput({tag, "_sel"}, 32'(sel), modelSel);
      checkOutput({tag, "_sb_drained"}, sbq.size(), 0);
   endtask

   initial begin
      reset = 1'b1;
      enc_a = 1'b1;
      enc_b = 1'b1;
      btn   = 1'b0;
      @(negedge clk);
      doReset();

      // Idle-high pins after reset must not produce a step
      repeat (50) @(negedge clk);
      checkOutput("idle_update", 32'(update), 0);
      checkOutput("idle_p0", 32'(params[7:0]), 128);
      checkOutput("idle_sel", 32'(sel), 0);
      checkState("idle");

      // Go straight to 00 (both pins together decode as no step), then two CW cycles
      applyStimulus(1'b0, 1'b0, 5);
      cwCycle();
      cwCycle();
      repeat (10) @(negedge clk);
      checkState("cw");

      // Preset param0 to the top, then three more up steps against the ceiling
      for (int i = 0; i < 100 && modelP[0] < 254; i++) cwCycle();
      applyStimulus(1'b1, 1'b0, 3);
      applyStimulus(1'b1, 1'b1, 3);
      applyStimulus(1'b0, 1'b1, 3);
      applyStimulus(1'b0, 1'b0, 3);
      applyStimulus(1'b1, 1'b0, 3);
      applyStimulus(1'b0, 1'b0, 10);
      checkOutput("sat_max_p0", 32'(params[7:0]), 255);
      checkState("sat_max");

      // Short press, then a bounced press that settles long enough
      pressButton(10, 30);
      checkOutput("short_press_sel", 32'(sel), 0);
      pressButton(5, 2);
      pressButton(20, 30);
      checkOutput("bounce_press_sel", 32'(sel), 1);
      checkState("bounce");

      // Step register and advance pulse coincide: step must land on param1
      btn = 1'b1;
      repeat (15) @(negedge clk);
      applyStimulus(1'b1, 1'b0, 10);
      btn = 1'b0;
      repeat (30) @(negedge clk);
      modelSel = 2;
      applyStimulus(1'b0, 1'b0, 5);
      checkOutput("coincide_sel", 32'(sel), 2);
      checkState("coincide");

      // Drive param2 to the floor, then three more down steps
      for (int i = 0; i < 100 && modelP[2] > 0; i++) ccwCycle();
      applyStimulus(1'b0, 1'b1, 3);
      applyStimulus(1'b1, 1'b1, 3);
      applyStimulus(1'b1, 1'b0, 3);
      applyStimulus(1'b0, 1'b0, 3);
      applyStimulus(1'b0, 1'b1, 3);
      applyStimulus(1'b0, 1'b0, 10);
      checkOutput("sat_min_p2", 32'(params[23:16]), 0);
      checkState("sat_min");

      // Full presses wrap the selection 2 -> 0 -> 1 -> 2 -> 0
      pressButton(20, 30);
      checkOutput("wrap_sel0", 32'(sel), 0);
      pressButton(20, 30);
      pressButton(20, 30);
      pressButton(20, 30);
      checkOutput("wrap_sel_final", 32'(sel), 0);
      checkState("wrap");

`ifdef ENC_ACCEL_EN
      doReset();
      repeat (10) @(negedge clk);
      applyStimulus(1'b1, 1'b0, 97);
      applyStimulus(1'b1, 1'b1, 3);
      applyStimulus(1'b0, 1'b1, 20);
      checkOutput("accel_fast_p0", 32'(params[7:0]), 133);
      applyStimulus(1'b0, 1'b0, 5000);
      applyStimulus(1'b1, 1'b0, 20);
      checkOutput("accel_slow_p0", 32'(params[7:0]), 134);
      applyStimulus(1'b0, 1'b0, 5);
      checkState("accel");
`endif

      // Reset in the middle of a press debounce returns selection to 0 with no late advance
      pressButton(20, 30);
      checkOutput("pre_reset_sel", 32'(sel), 1);
      btn = 1'b1;
      repeat (8) @(negedge clk);
      btn = 1'b0;
      doReset();
      repeat (40) @(negedge clk);
      checkOutput("mid_debounce_reset_sel", 32'(sel), 0);
      checkState("mid_reset");

      // Button held through reset yields exactly one advance
      btn = 1'b1;
      doReset();
      repeat (30) @(negedge clk);
      btn = 1'b0;
      repeat (30) @(negedge clk);
      modelSel = 1;
      checkOutput("held_reset_sel", 32'(sel), 1);
      checkState("held_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
